alu_con_flags: RTL and testbench
================================

Name: alu_con_flags

Overview:
- Parameterised-width integer ALU with four operations: ADD, SUB, XOR, NOT A.
- Produces a result and an NZCV condition-flag nibble.
- Inputs are sampled on a valid strobe; result and flags are registered, giving one-cycle latency.
- Sits in the ASIP execute stage and feeds the writeback path and the flag register used by conditional instructions.

Parameters:
- WIDTH, 17, operand and result width in bits (minimum 2).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  A, B and alu_control are valid this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B; ignored for NOT.
- alu_control  input  2  operation select: 00 ADD, 01 SUB, 10 XOR, 11 NOT A.
- result  output  WIDTH  registered operation result.
- alu_flags  output  4  registered flags {N,Z,C,V}; bit3 N, bit0 V.
- out_valid  output  1  result and alu_flags were updated by the previous cycle's in_valid.

Behaviour:
- Reset, asynchronous on rst=1: result=0, alu_flags=4'b0000, out_valid=0. Reset mid-operation discards any in-flight result.
- Latency: in_valid=1 at edge k updates result, alu_flags and out_valid=1 at edge k (visible in cycle k+1).
- in_valid=0 at an edge: out_valid=0; result and alu_flags hold their previous values.
- No backpressure; a new operation may be issued every cycle.
- Internal sum is WIDTH+1 bits: sum = a + bx + cin.
  - ADD: bx=b, cin=0.
  - SUB: bx=~b, cin=1.
  - Carry is sum[WIDTH].
- ADD/SUB result = sum[WIDTH-1:0]; wraps modulo 2^WIDTH.
- XOR result = a ^ b. NOT result = ~a.
- N = result[WIDTH-1], all operations.
- Z = (result == 0), all operations.
- C:
  - ADD: carry out.
  - SUB: carry out, i.e. 1 = no borrow (a >= b unsigned); a == b gives C=1.
  - XOR/NOT: 0.
- V, two's-complement signed overflow:
  - ADD: a[MSB]==b[MSB] and result[MSB]!=a[MSB].
  - SUB: a[MSB]!=b[MSB] and result[MSB]!=a[MSB].
  - XOR/NOT: 0.
- Flags are computed from the same cycle's result and registered together with it.
- No X propagation: all four alu_control codes are defined.

Optional Feature:
- Macro ALU_CON_FLAGS_STICKY_V_EN.
- Defined:
  - Adds input clr_sticky (1 bit) and output v_sticky (1 bit).
  - v_sticky is set at any edge where in_valid=1 and the computed V=1.
  - clr_sticky=1 clears it; set wins over clear in the same cycle.
  - rst clears it to 0.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset: assert rst asynchronously with random inputs -> result=0, alu_flags=0000, out_valid=0 immediately, without waiting for a clock edge.
- SUB (WIDTH=17):
  - a=5, b=2 -> result=3, NZCV=0010.
  - a=2, b=5 -> result=17'h1FFFD, NZCV=1000.
  - a=2, b=2 -> result=0, NZCV=0110.
  - Each appears one cycle after in_valid; out_valid pulses for one cycle.
- XOR:
  - a=5, b=2 -> 7, NZCV=0000.
  - a=2, b=5 -> 7, NZCV=0000.
  - a=2, b=2 -> 0, NZCV=0100.
- ADD:
  - a=17'h0FFFF, b=1 -> 17'h10000, NZCV=1001.
  - a=17'h1FFFF, b=1 -> 0, NZCV=0110.
  - a=3, b=17'h1FFF2 -> 17'h1FFF5, NZCV=1000.
- NOT: a=3 -> 17'h1FFFC, NZCV=1000; b ignored (try b=all ones and b=0, same response).
- Hold and sticky:
  - in_valid=0 for 3 cycles after an operation -> outputs unchanged, out_valid=0.
  - With ALU_CON_FLAGS_STICKY_V_EN defined: the overflow ADD sets v_sticky, which persists through later non-overflow operations until clr_sticky.

Source files
------------

// File: rtl/alu_con_flags.sv
// Registered ADD/SUB/XOR/NOT ALU with NZCV flags. One-cycle latency, no backpressure (accepts every cycle).
// Optional sticky overflow bit (v_sticky, cleared by clr_sticky) when ALU_CON_FLAGS_STICKY_V_EN is defined.
module alu_con_flags #(
    parameter int WIDTH = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       alu_control,
`ifdef ALU_CON_FLAGS_STICKY_V_EN
    input  logic             clr_sticky,
    output logic             v_sticky,
`endif
    output logic [WIDTH-1:0] result,
    output logic [3:0]       alu_flags,
    output logic             out_valid
);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_NOT = 2'b11;

    localparam int MSB = WIDTH - 1;

    logic             is_sub;
    logic [WIDTH-1:0] bx;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] nxt_result;
    logic             nxt_c;
    logic             nxt_v;
    logic             nxt_n;
    logic             nxt_z;

    // SUB reuses the adder as a + ~b + 1, so carry out means "no borrow".
    always_comb begin
        is_sub = (alu_control == OP_SUB);
        bx     = is_sub ? ~b : b;
        sum    = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, is_sub};
    end

    always_comb begin
        nxt_result = sum[WIDTH-1:0];
        nxt_c      = 1'b0;
        nxt_v      = 1'b0;
        case (alu_control)
            OP_ADD: begin
                nxt_result = sum[WIDTH-1:0];
                nxt_c      = sum[WIDTH];
                nxt_v      = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
            end
            OP_SUB: begin
                nxt_result = sum[WIDTH-1:0];
                nxt_c      = sum[WIDTH];
                nxt_v      = (a[MSB] != b[MSB]) && (sum[MSB] != a[MSB]);
            end
            OP_XOR: nxt_result = a ^ b;
            OP_NOT: nxt_result = ~a;
            default: nxt_result = sum[WIDTH-1:0];
        endcase
        nxt_n = nxt_result[MSB];
        nxt_z = (nxt_result == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result    <= '0;
            alu_flags <= 4'b0000;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                result    <= nxt_result;
                alu_flags <= {nxt_n, nxt_z, nxt_c, nxt_v};
            end
        end
    end

`ifdef ALU_CON_FLAGS_STICKY_V_EN
    // A new overflow in the same cycle as a clear keeps the bit set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_sticky <= 1'b0;
        end else if (in_valid && nxt_v) begin
            v_sticky <= 1'b1;
        end else if (clr_sticky) begin
            v_sticky <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_alu_con_flags.sv
// Self-checking bench for alu_con_flags: directed literal cases plus randomized traffic against an arithmetic model.
module tb_alu_con_flags;

    localparam int W = 17;
    localparam logic [W-1:0] ALL1 = {W{1'b1}};

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [1:0]   alu_control = 2'b00;
    logic [W-1:0] result;
    logic [3:0]   alu_flags;
    logic         out_valid;
`ifdef ALU_CON_FLAGS_STICKY_V_EN
    logic         clr_sticky = 1'b0;
    logic         v_sticky;
    logic         exp_sticky = 1'b0;
`endif

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    logic [W-1:0] exp_result = '0;
    logic [3:0]   exp_flags  = 4'b0000;
    logic         exp_valid  = 1'b0;

    alu_con_flags #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .a           (a),
        .b           (b),
        .alu_control (alu_control),
`ifdef ALU_CON_FLAGS_STICKY_V_EN
        .clr_sticky  (clr_sticky),
        .v_sticky    (v_sticky),
`endif
        .result      (result),
        .alu_flags   (alu_flags),
        .out_valid   (out_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    // Reference: plain unsigned/signed integer arithmetic on the operand values.
    function automatic void model_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                     input logic [1:0] op,
                                     output logic [W-1:0] r, output logic [3:0] f);
        longint m, ua, ub, sa, sb, full, sres, smax, smin;
        logic c, v;
        m    = 64'sd1 <<< W;
        smax = (m / 2) - 1;
        smin = -(m / 2);
        ua   = longint'(ia);
        ub   = longint'(ib);
        sa   = ia[W-1] ? ua - m : ua;
        sb   = ib[W-1] ? ub - m : ub;
        c    = 1'b0;
        v    = 1'b0;
        r    = '0;
        case (op)
            2'b00: begin
                full = ua + ub;
                r    = full[W-1:0];
                c    = (full >= m);
                sres = sa + sb;
                v    = (sres > smax) || (sres < smin);
            end
            2'b01: begin
                full = ua - ub + m;
                r    = full[W-1:0];
                c    = (ua >= ub);
                sres = sa - sb;
                v    = (sres > smax) || (sres < smin);
            end
            2'b10: r = ia ^ ib;
            default: r = ~ia;
        endcase
        f = {r[W-1], (r == '0), c, v};
    endfunction

    always @(posedge clk or posedge rst) begin
        logic [W-1:0] r;
        logic [3:0]   f;
        if (rst) begin
            exp_result = '0;
            exp_flags  = 4'b0000;
            exp_valid  = 1'b0;
`ifdef ALU_CON_FLAGS_STICKY_V_EN
            exp_sticky = 1'b0;
`endif
        end else begin
            model_op(a, b, alu_control, r, f);
            exp_valid = in_valid;
            if (in_valid) begin
                exp_result = r;
                exp_flags  = f;
            end
`ifdef ALU_CON_FLAGS_STICKY_V_EN
            if (in_valid && f[0]) exp_sticky = 1'b1;
            else if (clr_sticky)  exp_sticky = 1'b0;
`endif
        end
    end

    always @(negedge clk) begin
        if (cmp_en && !rst) begin
            chk("model_out_valid", 32'(out_valid), 32'(exp_valid));
            chk("model_result",    32'(result),    32'(exp_result));
            chk("model_flags",     32'(alu_flags), 32'(exp_flags));
`ifdef ALU_CON_FLAGS_STICKY_V_EN
            chk("model_v_sticky",  32'(v_sticky),  32'(exp_sticky));
`endif
        end
    end

    task automatic run_lit(input string nm, input logic [1:0] op,
                           input logic [W-1:0] ia, input logic [W-1:0] ib,
                           input logic [W-1:0] er, input logic [3:0] ef);
        @(negedge clk);
        a = ia; b = ib; alu_control = op; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; a = W'($urandom); b = W'($urandom);
        alu_control = 2'($urandom);
        chk({nm, "_result"}, 32'(result), 32'(er));
        chk({nm, "_flags"},  32'(alu_flags), 32'(ef));
        chk({nm, "_vld_hi"}, 32'(out_valid), 32'd1);
        @(negedge clk);
        chk({nm, "_vld_lo"}, 32'(out_valid), 32'd0);
    endtask

    task automatic async_reset(input string nm);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk({nm, "_result"},    32'(result),    32'd0);
        chk({nm, "_flags"},     32'(alu_flags), 32'd0);
        chk({nm, "_out_valid"}, 32'(out_valid), 32'd0);
`ifdef ALU_CON_FLAGS_STICKY_V_EN
        chk({nm, "_v_sticky"},  32'(v_sticky),  32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return {{(W-1){1'b0}}, 1'b1};
            2: return ALL1;
            3: return {1'b1, {(W-1){1'b0}}};
            4: return {1'b0, {(W-1){1'b1}}};
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        // Random inputs driven with in_valid high before and during the first reset.
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            in_valid = 1'b1; a = W'($urandom); b = W'($urandom);
            alu_control = 2'($urandom);
        end
        async_reset("rst_initial");
        in_valid = 1'b0;
        cmp_en = 1'b1;

        run_lit("sub_5_2", 2'b01, 17'd5, 17'd2, 17'd3,       4'b0010);
        run_lit("sub_2_5", 2'b01, 17'd2, 17'd5, 17'h1FFFD,   4'b1000);
        run_lit("sub_2_2", 2'b01, 17'd2, 17'd2, 17'd0,       4'b0110);
        run_lit("xor_5_2", 2'b10, 17'd5, 17'd2, 17'd7,       4'b0000);
        run_lit("xor_2_5", 2'b10, 17'd2, 17'd5, 17'd7,       4'b0000);
        run_lit("xor_2_2", 2'b10, 17'd2, 17'd2, 17'd0,       4'b0100);
        run_lit("add_ovf", 2'b00, 17'h0FFFF, 17'd1, 17'h10000, 4'b1001);
`ifdef ALU_CON_FLAGS_STICKY_V_EN
        chk("sticky_set", 32'(v_sticky), 32'd1);
`endif
        run_lit("add_wrap", 2'b00, 17'h1FFFF, 17'd1, 17'd0,   4'b0110);
        run_lit("not_b1",   2'b11, 17'd3, ALL1,   17'h1FFFC,  4'b1000);
        run_lit("not_b0",   2'b11, 17'd3, 17'd0,  17'h1FFFC,  4'b1000);
        run_lit("add_neg",  2'b00, 17'd3, 17'h1FFF2, 17'h1FFF5, 4'b1000);

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_result",    32'(result),    32'h1FFF5);
            chk("hold_flags",     32'(alu_flags), 32'b1000);
            chk("hold_out_valid", 32'(out_valid), 32'd0);
            a = W'($urandom); b = W'($urandom);
        end

`ifdef ALU_CON_FLAGS_STICKY_V_EN
        chk("sticky_persist_add", 32'(v_sticky), 32'd1);
        run_lit("sub_after_ovf", 2'b01, 17'd5, 17'd2, 17'd3, 4'b0010);
        chk("sticky_persist_sub", 32'(v_sticky), 32'd1);
        @(negedge clk);
        clr_sticky = 1'b1;
        @(negedge clk);
        clr_sticky = 1'b0;
        chk("sticky_cleared", 32'(v_sticky), 32'd0);
        // Overflow and clear in the same cycle: set takes priority.
        @(negedge clk);
        a = 17'h0FFFF; b = 17'd1; alu_control = 2'b00; in_valid = 1'b1; clr_sticky = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; clr_sticky = 1'b0;
        chk("sticky_set_wins", 32'(v_sticky), 32'd1);
`endif

        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            in_valid    = ($urandom_range(0, 9) < 7);
            a           = pick();
            b           = pick();
            alu_control = 2'($urandom);
`ifdef ALU_CON_FLAGS_STICKY_V_EN
            clr_sticky  = ($urandom_range(0, 15) == 0);
`endif
            if (i == 700) begin
                in_valid = 1'b1;
                async_reset("rst_midrun");
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
